tag_lookup_sequencer: RTL

Sequences one L2 set lookup by scanning the tag array way by way and comparing each stored tag against the request tag with a single shared equality comparator. Sits between the L2 request front end and the tag array. Returns hit/miss and the hit way over a valid/ready handshake. Keeps saturating hit/miss statistics for the simulator.

---
 rtl/tag_lookup_sequencer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/tag_lookup_sequencer.sv
// Sequential L2 set lookup: scans the tag array one way per cycle through a
// single shared comparator and returns hit/miss plus hit way over valid/ready.
module tag_lookup_sequencer #(
   parameter int unsigned TAG_BITS = 12,
   parameter int unsigned WAYS     = 8,
   parameter int unsigned WAY_BITS = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [TAG_BITS-1:0] req_tag,
   output logic                rd_en,
   output logic [WAY_BITS-1:0] rd_way,
   input  logic [TAG_BITS-1:0] rd_tag,
   input  logic                rd_valid,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic                resp_hit,
   output logic [WAY_BITS-1:0] resp_way,
   output logic [31:0]         hit_count,
   output logic [31:0]         miss_count
);

   localparam int unsigned CNT_W = 32;
   // Issue pointer must be able to hold WAYS itself to mark "all ways issued".
   localparam int unsigned PTR_W = WAY_BITS + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   state_e              state_q,      state_d;
   logic [TAG_BITS-1:0] tag_q,        tag_d;
   logic [PTR_W-1:0]    issue_ptr_q,  issue_ptr_d;
   logic                cmp_valid_q,  cmp_valid_d;
   logic [WAY_BITS-1:0] cmp_way_q,    cmp_way_d;
   logic                req_ready_q,  req_ready_d;
   logic                rd_en_q,      rd_en_d;
   logic [WAY_BITS-1:0] rd_way_q,     rd_way_d;
   logic                resp_valid_q, resp_valid_d;
   logic                resp_hit_q,   resp_hit_d;
   logic [WAY_BITS-1:0] resp_way_q,   resp_way_d;
   logic [CNT_W-1:0]    hit_count_q,  hit_count_d;
   logic [CNT_W-1:0]    miss_count_q, miss_count_d;

   logic tag_match_c;
   logic last_way_c;

   // Shared comparator: data returned for the way issued last cycle.
   always_comb begin
      tag_match_c = cmp_valid_q && rd_valid && (rd_tag == tag_q);
      last_way_c  = cmp_valid_q && (cmp_way_q == WAY_BITS'(WAYS - 1));
   end

   // Next-state and registered-output decode.
   always_comb begin
      state_d      = state_q;
      tag_d        = tag_q;
      issue_ptr_d  = issue_ptr_q;
      cmp_valid_d  = cmp_valid_q;
      cmp_way_d    = cmp_way_q;
      req_ready_d  = req_ready_q;
      rd_en_d      = rd_en_q;
      rd_way_d     = rd_way_q;
      resp_valid_d = resp_valid_q;
      resp_hit_d   = resp_hit_q;
      resp_way_d   = resp_way_q;
      hit_count_d  = hit_count_q;
      miss_count_d = miss_count_q;

      unique case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               state_d     = ST_SCAN;
               tag_d       = req_tag;
               req_ready_d = 1'b0;
               rd_en_d     = 1'b1;
               rd_way_d    = '0;
               issue_ptr_d = PTR_W'(1);
               cmp_valid_d = 1'b0;
               cmp_way_d   = '0;
            end
         end

         ST_SCAN: begin
            // The read on the bus this cycle is compared next cycle.
            cmp_valid_d = rd_en_q;
            cmp_way_d   = rd_way_q;
            if (issue_ptr_q < PTR_W'(WAYS)) begin
               rd_en_d     = 1'b1;
               rd_way_d    = issue_ptr_q[WAY_BITS-1:0];
               issue_ptr_d = issue_ptr_q + PTR_W'(1);
            end else begin
               rd_en_d = 1'b0;
            end

            if (tag_match_c) begin
               state_d      = ST_RESP;
               rd_en_d      = 1'b0;
               cmp_valid_d  = 1'b0;
               resp_valid_d = 1'b1;
               resp_hit_d   = 1'b1;
               resp_way_d   = cmp_way_q;
            end else if (last_way_c) begin
               state_d      = ST_RESP;
               rd_en_d      = 1'b0;
               cmp_valid_d  = 1'b0;
               resp_valid_d = 1'b1;
               resp_hit_d   = 1'b0;
               resp_way_d   = '0;
            end
         end

         ST_RESP: begin
            if (resp_ready) begin
               state_d      = ST_IDLE;
               resp_valid_d = 1'b0;
               req_ready_d  = 1'b1;
               if (resp_hit_q) begin
                  if (hit_count_q != '1) hit_count_d = hit_count_q + CNT_W'(1);
               end else begin
                  if (miss_count_q != '1) miss_count_d = miss_count_q + CNT_W'(1);
               end
            end
         end

         default: begin
            state_d      = ST_IDLE;
            req_ready_d  = 1'b1;
            rd_en_d      = 1'b0;
            resp_valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset drops any scan or response in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         tag_q        <= '0;
         issue_ptr_q  <= '0;
         cmp_valid_q  <= 1'b0;
         cmp_way_q    <= '0;
         req_ready_q  <= 1'b1;
         rd_en_q      <= 1'b0;
         rd_way_q     <= '0;
         resp_valid_q <= 1'b0;
         resp_hit_q   <= 1'b0;
         resp_way_q   <= '0;
         hit_count_q  <= '0;
         miss_count_q <= '0;
      end else begin
         state_q      <= state_d;
         tag_q        <= tag_d;
         issue_ptr_q  <= issue_ptr_d;
         cmp_valid_q  <= cmp_valid_d;
         cmp_way_q    <= cmp_way_d;
         req_ready_q  <= req_ready_d;
         rd_en_q      <= rd_en_d;
         rd_way_q     <= rd_way_d;
         resp_valid_q <= resp_valid_d;
         resp_hit_q   <= resp_hit_d;
         resp_way_q   <= resp_way_d;
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign rd_en      = rd_en_q;
   assign rd_way     = rd_way_q;
   assign resp_valid = resp_valid_q;
   assign resp_hit   = resp_hit_q;
   assign resp_way   = resp_way_q;
   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;

endmodule
